// File: rtl/tx_link_pkg.sv
// Shared link-layer definitions: controller state codes and stream-select
// codes used by tx_link_ctrl and the downstream tx_link_layer.
package tx_link_pkg;

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILA  = 2'd1,
        ST_DATA = 2'd2,
        ST_RSVD = 2'd3
    } link_state_t;

    localparam logic [2:0] MUX_USER = 3'd0;
    localparam logic [2:0] MUX_K    = 3'd1;
    localparam logic [2:0] MUX_ILA  = 3'd2;

    // Number of multiframes in the initial lane alignment sequence.
    localparam int ILA_MF_COUNT = 4;

    // Stream select for a given state; the reserved code behaves as CGS.
    function automatic logic [2:0] state_to_mux(input link_state_t s);
        logic [2:0] m;
        case (s)
            ST_ILA:  m = MUX_ILA;
            ST_DATA: m = MUX_USER;
            default: m = MUX_K;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lmfc_counter.sv
// Local multiframe clock counter: counts 0..FK-1 every clock and wraps.
// A SYSREF pulse forces the count back to 0 on the next cycle.
module lmfc_counter #(
    parameter int FK = 4,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_sysref,
    output logic [CW-1:0] o_cnt,
    output logic          o_edge,
    output logic          o_last
);

    localparam logic [CW-1:0] LAST = CW'(FK - 1);

    logic [CW-1:0] cnt;

    // Free-running counter with SYSREF realignment taking priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (i_sysref) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_cnt  = cnt;
    assign o_edge = (cnt == '0);
    assign o_last = (cnt == LAST);

endmodule

// File: rtl/tx_link_ctrl.sv
// Transmit link controller: sequences CGS -> ILA -> DATA from SYSREF-aligned
// LMFC timing and the receiver's SYNC~, and detects resync requests.
// Optional feature macro: TX_LINK_CTRL_ERR_CNT_EN enables the saturating
// SYNC~ error-report counter on o_err_cnt (tied to 0 when undefined).
//
// o_user_ready is a ready-only handshake: while it is high, the user octet
// presented on each clock is consumed by the link layer that cycle; there is
// no valid qualifier, the user source must always have an octet available.
module tx_link_ctrl
    import tx_link_pkg::*;
#(
    parameter int F          = 1,
    parameter int K          = 32,
    parameter int RESYNC_OCT = 5 * F + 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sync_n,
    input  logic       i_sysref,
    output logic [2:0] o_link_mux,
    output logic [1:0] o_state,
    output logic       o_lmfc_edge,
    output logic [1:0] o_ila_mf_idx,
    output logic       o_ila_mf_start,
    output logic       o_user_ready,
    output logic [7:0] o_err_cnt
);

    localparam int FK = F * K;
    localparam int CW = (FK > 1) ? $clog2(FK) : 1;
    localparam int LW = $clog2(RESYNC_OCT + 1);
    localparam logic [LW-1:0] LOW_MAX = LW'(RESYNC_OCT);
    localparam logic [1:0]    IDX_LAST = 2'(ILA_MF_COUNT - 1);

    link_state_t   state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [LW-1:0] low_run, low_run_nxt;
    logic          report;
    logic [CW-1:0] lmfc_cnt;
    logic          lmfc_edge;
    logic          lmfc_last;

    lmfc_counter #(
        .FK (FK),
        .CW (CW)
    ) u_lmfc (
        .clk      (clk),
        .rst      (rst),
        .i_sysref (i_sysref),
        .o_cnt    (lmfc_cnt),
        .o_edge   (lmfc_edge),
        .o_last   (lmfc_last)
    );

    // State, ILA multiframe index and SYNC~ low-run registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CGS;
            idx     <= '0;
            low_run <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            low_run <= low_run_nxt;
        end
    end

    // Next-state logic: SYSREF in CGS/ILA restarts alignment, SYNC~ runs in DATA.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        low_run_nxt = low_run;
        report      = 1'b0;
        case (state)
            ST_CGS: begin
                idx_nxt     = '0;
                low_run_nxt = '0;
                if (i_sync_n && lmfc_last && !i_sysref) begin
                    state_nxt = ST_ILA;
                end
            end
            ST_ILA: begin
                low_run_nxt = '0;
                if (!i_sync_n || i_sysref) begin
                    state_nxt = ST_CGS;
                    idx_nxt   = '0;
                end else if (lmfc_last) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = ST_DATA;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                idx_nxt = '0;
                if (!i_sync_n) begin
                    low_run_nxt = (low_run == LOW_MAX) ? low_run : low_run + 1'b1;
                    if (low_run_nxt == LOW_MAX) begin
                        state_nxt = ST_CGS;
                    end
                end else begin
                    // A short low pulse that did not reach resync length is an error report.
                    if ((low_run != '0) && (low_run < LOW_MAX)) begin
                        report = 1'b1;
                    end
                    low_run_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_CGS;
                idx_nxt     = '0;
                low_run_nxt = '0;
            end
        endcase
    end

`ifdef TX_LINK_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt;

    // Saturating count of SYNC~ error reports, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (report && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign o_err_cnt = err_cnt;
`else
    logic report_unused;
    assign report_unused = report;
    assign o_err_cnt     = '0;
`endif

    assign o_link_mux     = state_to_mux(state);
    assign o_state        = (state == ST_RSVD) ? 2'(ST_CGS) : 2'(state);
    assign o_lmfc_edge    = lmfc_edge;
    assign o_ila_mf_idx   = idx;
    assign o_ila_mf_start = (state == ST_ILA) && lmfc_edge;
    assign o_user_ready   = (state == ST_DATA);

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Directed testbench for tx_link_ctrl with F=1, K=4, RESYNC_OCT=14.
module tb_tx_link_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync_n;
    logic       sysref;
    logic [2:0] link_mux;
    logic [1:0] state;
    logic       lmfc_edge;
    logic [1:0] mf_idx;
    logic       mf_start;
    logic       user_ready;
    logic [7:0] err_cnt;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;
    int exp_err = 0;

    // Clock and reset block
    always #5 clk = ~clk;

    tx_link_ctrl #(
        .F          (1),
        .K          (4),
        .RESYNC_OCT (14)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_sync_n       (sync_n),
        .i_sysref       (sysref),
        .o_link_mux     (link_mux),
        .o_state        (state),
        .o_lmfc_edge    (lmfc_edge),
        .o_ila_mf_idx   (mf_idx),
        .o_ila_mf_start (mf_start),
        .o_user_ready   (user_ready),
        .o_err_cnt      (err_cnt)
    );

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    // Advance one clock; LMFC reference model follows the driven inputs.
    task automatic step();
        if (rst || sysref) exp_cnt = 0;
        else exp_cnt = (exp_cnt + 1) % 4;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sync_n = 1'b0; sysref = 1'b0;
        step();
        rst = 1'b0;
        exp_err = 0;
        checks++; if (link_mux !== 3'd1) begin errors++; $display("FAIL rst_mux: got %0d want 1", link_mux); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
        checks++; if (lmfc_edge !== 1'b1) begin errors++; $display("FAIL rst_edge: got %0d want 1", lmfc_edge); end
        checks++; if (mf_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %0d want 0", mf_start); end
        checks++; if (user_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0d want 0", user_ready); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err: got %0d want 0", err_cnt); end
        checks++; if (mf_idx !== 2'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", mf_idx); end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (link_mux !== 3'd1 || user_ready !== 1'b0 || state !== 2'd0) begin
                errors++;
                $display("FAIL cgs_hold[%0d]: got mux %0d rdy %0d st %0d want 1 0 0", i, link_mux, user_ready, state);
            end
            checks++;
            if (lmfc_edge !== (exp_cnt == 0)) begin
                errors++;
                $display("FAIL lmfc_edge[%0d]: got %0d want %0d", i, lmfc_edge, (exp_cnt == 0));
            end
            step();
        end
    endtask

    task automatic check_ila_run(input string tag);
        int starts;
        logic [1:0] e_idx;
        starts = 0;
        for (int i = 0; i < 16; i++) begin
            e_idx = 2'(i / 4);
            checks++;
            if (link_mux !== 3'd2 || mf_idx !== e_idx || mf_start !== (i % 4 == 0)) begin
                errors++;
                $display("FAIL %s[%0d]: got mux %0d idx %0d start %0d want 2 %0d %0d",
                         tag, i, link_mux, mf_idx, mf_start, e_idx, (i % 4 == 0));
            end
            if (mf_start === 1'b1) starts++;
            step();
        end
        checks++;
        if (starts != 4) begin errors++; $display("FAIL %s_starts: got %0d want 4", tag, starts); end
        checks++;
        if (state !== 2'd2 || link_mux !== 3'd0 || user_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_data: got st %0d mux %0d rdy %0d want 2 0 1", tag, state, link_mux, user_ready);
        end
    endtask

    task automatic test_ila_entry();
        step();  // counter now 1
        sync_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 2'd0) begin errors++; $display("FAIL cgs_wait[%0d]: got %0d want 0", i, state); end
            step();
        end
        checks++;
        if (state !== 2'd1 || lmfc_edge !== 1'b1) begin
            errors++;
            $display("FAIL ila_enter: got st %0d edge %0d want 1 1", state, lmfc_edge);
        end
        check_ila_run("ila1");
    endtask

    task automatic test_short_drop();
        sync_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (state !== 2'd2) begin errors++; $display("FAIL short_low[%0d]: got %0d want 2", i, state); end
        end
        sync_n = 1'b1;
        step();
`ifdef TX_LINK_CTRL_ERR_CNT_EN
        exp_err = exp_err + 1;
`endif
        checks++;
        if (state !== 2'd2 || err_cnt !== 8'(exp_err)) begin
            errors++;
            $display("FAIL short_report: got st %0d err %0d want 2 %0d", state, err_cnt, exp_err);
        end
    endtask

    task automatic test_near_miss();
        sync_n = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step();
            checks++;
            if (state !== 2'd2) begin errors++; $display("FAIL near_low[%0d]: got %0d want 2", i, state); end
        end
        sync_n = 1'b1;
        step();
`ifdef TX_LINK_CTRL_ERR_CNT_EN
        exp_err = exp_err + 1;
`endif
        checks++;
        if (state !== 2'd2 || err_cnt !== 8'(exp_err)) begin
            errors++;
            $display("FAIL near_report: got st %0d err %0d want 2 %0d", state, err_cnt, exp_err);
        end
    endtask

    task automatic test_resync();
        sync_n = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            step();
            checks++;
            if (i < 14) begin
                if (state !== 2'd2) begin errors++; $display("FAIL resync_low[%0d]: got %0d want 2", i, state); end
            end else begin
                if (state !== 2'd0 || link_mux !== 3'd1 || user_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL resync_cgs: got st %0d mux %0d rdy %0d want 0 1 0", state, link_mux, user_ready);
                end
            end
        end
        checks++;
        if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL resync_err: got %0d want %0d", err_cnt, exp_err); end
    endtask

    task automatic test_ila_sysref();
        for (int i = 0; i < 4; i++) if (exp_cnt != 3) step();
        // SYSREF coincides with the CGS exit condition: SYSREF wins.
        sync_n = 1'b1; sysref = 1'b1;
        step();
        sysref = 1'b0;
        checks++;
        if (state !== 2'd0 || lmfc_edge !== 1'b1) begin
            errors++;
            $display("FAIL sysref_tie: got st %0d edge %0d want 0 1", state, lmfc_edge);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL ila2_enter: got %0d want 1", state); end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (state !== 2'd1 || mf_idx !== 2'd2) begin
            errors++;
            $display("FAIL ila_idx2: got st %0d idx %0d want 1 2", state, mf_idx);
        end
        sysref = 1'b1;
        step();
        sysref = 1'b0;
        checks++;
        if (state !== 2'd0 || mf_idx !== 2'd0 || link_mux !== 3'd1 || lmfc_edge !== 1'b1) begin
            errors++;
            $display("FAIL ila_sysref: got st %0d idx %0d mux %0d edge %0d want 0 0 1 1", state, mf_idx, link_mux, lmfc_edge);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (state !== 2'd0) begin errors++; $display("FAIL realign_wait[%0d]: got %0d want 0", i, state); end
        end
        step();
        check_ila_run("ila3");
    endtask

    task automatic test_rst_in_data();
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL pre_rst_data: got %0d want 2", state); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_err = 0;
        checks++;
        if (link_mux !== 3'd1 || state !== 2'd0 || lmfc_edge !== 1'b1 || mf_start !== 1'b0 ||
            user_ready !== 1'b0 || err_cnt !== 8'd0 || mf_idx !== 2'd0) begin
            errors++;
            $display("FAIL data_rst: got mux %0d st %0d edge %0d start %0d rdy %0d err %0d idx %0d want 1 0 1 0 0 0 0",
                     link_mux, state, lmfc_edge, mf_start, user_ready, err_cnt, mf_idx);
        end
    endtask

    task automatic test_ila_drop();
        sync_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL drop_enter: got %0d want 1", state); end
        step();
        sync_n = 1'b0;
        step();
        checks++;
        if (state !== 2'd0 || mf_idx !== 2'd0 || link_mux !== 3'd1) begin
            errors++;
            $display("FAIL ila_drop: got st %0d idx %0d mux %0d want 0 0 1", state, mf_idx, link_mux);
        end
    endtask

    initial begin
        rst = 1'b1; sync_n = 1'b0; sysref = 1'b0;
        test_reset();
        test_ila_entry();
        test_short_drop();
        test_near_miss();
        test_resync();
        test_ila_sysref();
        test_rst_in_data();
        test_ila_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_link_ctrl.md
TX_LINK_CTRL -- requirements
Module: tx_link_ctrl

Interface
REQ-001 Parameter F, default 1, octets per frame (1..256).
REQ-002 Parameter K, default 32, frames per multiframe (1..32); F*K >= 4.
REQ-003 Parameter RESYNC_OCT, default 5*F+9, consecutive low SYNC~ octets that constitute a resync request.
REQ-004 clk  in  1  character clock; one clock; reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_sync_n  in  1  SYNC~ from receiver, already synchronous to clk.
REQ-007 i_sysref  in  1  single-cycle LMFC alignment pulse.
REQ-008 o_link_mux  out  3  link-layer stream select: 0 user data, 1 continuous K, 2 ILA.
REQ-009 o_state  out  2  current state code.
REQ-010 o_lmfc_edge  out  1  high when LMFC counter == 0.
REQ-011 o_ila_mf_idx  out  2  ILA multiframe index 0..3; 0 outside ILA.
REQ-012 o_ila_mf_start  out  1  high on first octet of each ILA multiframe.
REQ-013 o_user_ready  out  1  high while in DATA; user octets are consumed.
REQ-014 o_err_cnt  out  8  SYNC~ error-report count.

Function
REQ-015 LMFC counter counts 0..F*K-1 every clk, wraps to 0.
REQ-016 i_sysref high: counter = 0 on the next cycle, overriding the increment.
REQ-017 States: CGS(0), ILA(1), DATA(2); code 3 unreachable, decodes to CGS.
REQ-018 o_link_mux = 1 in CGS, 2 in ILA, 0 in DATA; all outputs decoded from registered state/counters, no extra latency.
REQ-019 CGS->ILA when i_sync_n==1 and LMFC counter == F*K-1; first ILA cycle has counter 0.
REQ-020 ILA: o_ila_mf_idx increments when counter == F*K-1; at idx 3 and counter == F*K-1, go to DATA; ILA lasts exactly 4*F*K cycles.
REQ-021 ILA: i_sync_n==0 on any cycle -> CGS next cycle, idx cleared.
REQ-022 ILA: i_sysref -> CGS next cycle, idx cleared, ILA restarts from CGS rules.
REQ-023 DATA: low-run counter counts consecutive cycles with i_sync_n==0 and saturates at RESYNC_OCT.
REQ-024 DATA: low-run reaching RESYNC_OCT -> CGS next cycle (resync).
REQ-025 DATA: i_sync_n returns high with low-run in 1..RESYNC_OCT-1 -> one error report; low-run cleared.
REQ-026 DATA: i_sysref realigns counter only; state unchanged.
REQ-027 CGS: i_sync_n==1 at counter != F*K-1 waits; SYNC~ toggling in CGS is no error.
REQ-028 Simultaneous i_sysref and CGS->ILA condition: sysref wins, stay CGS.

Reset
REQ-029 rst high: state CGS, LMFC counter 0, low-run 0, o_ila_mf_idx 0, o_err_cnt 0.
REQ-030 Reset outputs: o_link_mux 1, o_state 0, o_lmfc_edge 1, o_ila_mf_start 0, o_user_ready 0.
REQ-031 Reset mid-ILA or mid-DATA takes effect on the next edge, no partial state kept.

Configuration
REQ-032 Macro TX_LINK_CTRL_ERR_CNT_EN defined: o_err_cnt increments by 1 per REQ-025 report, saturates at 255, clears only on rst.
REQ-033 Macro undefined: error counter logic absent; o_err_cnt tied to 0; reports still clear low-run.

Structure
REQ-034 Shared package/include tx_link_pkg holds state codes (CGS/ILA/DATA) and link-mux codes (0/1/2), for use by tx_link_layer and this block.
REQ-035 One sub-module lmfc_counter (counter, sysref realign, edge and last-octet flags); FSM in tx_link_ctrl.

Verification (F=1, K=4, RESYNC_OCT=14)
REQ-036 rst, i_sync_n=0 for 20 cycles -> o_link_mux=1, o_user_ready=0, o_state=0 throughout.
REQ-037 Raise i_sync_n while counter=1 -> ILA starts the cycle counter=0; mux=2 for 16 cycles, idx 0,1,2,3, o_ila_mf_start pulses 4 times; then mux=0, o_user_ready=1.
REQ-038 In DATA, i_sync_n low 3 cycles -> stays DATA; o_err_cnt=1 with macro, 0 without.
REQ-039 In DATA, i_sync_n low 14 cycles -> CGS on cycle 15, mux=1; low 13 then high -> stays DATA, one report.
REQ-040 In ILA idx=2, pulse i_sysref -> CGS next cycle, idx=0; SYNC~ high -> full 16-cycle ILA again from new LMFC 0.
REQ-041 In DATA, pulse rst -> next cycle all outputs at REQ-030 values, o_err_cnt=0.
